// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_port_arbiter_if : IF/MEM requester ports and unified memory-port bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic [DATA_W-1:0]     if_rdata;
  logic                  if_valid;
  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_W-1:0]     dm_addr;
  logic [DATA_W-1:0]     dm_wdata;
  logic [DATA_W/8-1:0]   dm_wstrb;
  logic [DATA_W-1:0]     dm_rdata;
  logic                  dm_valid;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic                  mem_ready;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  stall_if;
  logic                  stall_mem;
  logic                  err;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
           mem_ready, mem_rdata,
    output if_rdata, if_valid, dm_rdata, dm_valid, mem_req, mem_we, mem_addr,
           mem_wdata, mem_wstrb, stall_if, stall_mem, err
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
           mem_ready, mem_rdata,
    input  if_rdata, if_valid, dm_rdata, dm_valid, mem_req, mem_we, mem_addr,
           mem_wdata, mem_wstrb, stall_if, stall_mem, err
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_port_arbiter : shares one memory port between fetch and load/store
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 16
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int                 c_CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MAX_WAIT - 1);
  localparam int                 c_STRB_W   = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    DM_WAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  state_t                r_state;
  state_t                w_state_nxt;
  owner_t                r_owner;
  logic [c_CNT_W-1:0]    r_cnt;
  logic                  w_timeout;

  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [DATA_W-1:0]     r_mem_wdata;
  logic [c_STRB_W-1:0]   r_mem_wstrb;
  logic [DATA_W-1:0]     r_if_rdata;
  logic [DATA_W-1:0]     r_dm_rdata;
  logic                  r_if_valid;
  logic                  r_dm_valid;
  logic                  r_err;

  // mem_ready takes priority over the timeout on the final wait cycle
  assign w_timeout = ~bus.mem_ready & (r_cnt == c_CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (bus.dm_req) begin
          w_state_nxt = DM_WAIT;
        end else if (bus.if_req) begin
          w_state_nxt = IF_WAIT;
        end
      end
      IF_WAIT, DM_WAIT: begin
        if (bus.mem_ready || w_timeout) begin
          w_state_nxt = RESP;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_owner     <= OWN_IF;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_if_valid  <= 1'b0;
      r_dm_valid  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_if_valid <= 1'b0;
      r_dm_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          // data side wins ties: the MEM-stage instruction is older
          if (bus.dm_req) begin
            r_owner     <= OWN_DM;
            r_mem_req   <= 1'b1;
            r_mem_we    <= bus.dm_we;
            r_mem_addr  <= bus.dm_addr;
            r_mem_wdata <= bus.dm_wdata;
            r_mem_wstrb <= bus.dm_wstrb;
          end else if (bus.if_req) begin
            r_owner     <= OWN_IF;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= bus.if_addr;
            r_mem_wstrb <= '0;
          end
        end
        IF_WAIT, DM_WAIT: begin
          if (bus.mem_ready) begin
            r_mem_req <= 1'b0;
            if (r_owner == OWN_IF) begin
              r_if_rdata <= bus.mem_rdata;
              r_if_valid <= 1'b1;
            end else begin
              if (!r_mem_we) begin
                r_dm_rdata <= bus.mem_rdata;
              end
              r_dm_valid <= 1'b1;
            end
          end else if (w_timeout) begin
            r_mem_req <= 1'b0;
            r_err     <= 1'b1;
            if (r_owner == OWN_IF) begin
              r_if_rdata <= '0;
              r_if_valid <= 1'b1;
            end else begin
              r_dm_rdata <= '0;
              r_dm_valid <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          r_cnt <= '0;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_wstrb = r_mem_wstrb;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.dm_rdata  = r_dm_rdata;
  assign bus.if_valid  = r_if_valid;
  assign bus.dm_valid  = r_dm_valid;
  assign bus.err       = r_err;
  assign bus.stall_if  = bus.if_req & ~r_if_valid;
  assign bus.stall_mem = bus.dm_req & ~r_dm_valid;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter : directed self-checking bench for mem_port_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // inputs change just after the rising edge, outputs are sampled on the falling edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
    bus.dm_wstrb  = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;

    // reset
    repeat (3) next_cycle();
    sample();
    check_eq("rst_mem_req",  bus.mem_req,  0);
    check_eq("rst_mem_addr", bus.mem_addr, 0);
    check_eq("rst_if_valid", bus.if_valid, 0);
    check_eq("rst_dm_valid", bus.dm_valid, 0);
    check_eq("rst_if_rdata", bus.if_rdata, 0);
    check_eq("rst_err",      bus.err,      0);
    next_cycle();
    rst_n = 1'b1;

    // 1: fetch with zero-wait memory
    next_cycle();
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h00500093;
    sample();
    check_eq("t1_c0_stall_if", bus.stall_if, 1);
    check_eq("t1_c0_mem_req",  bus.mem_req,  0);
    next_cycle(); sample();
    check_eq("t1_c1_mem_req",   bus.mem_req,   1);
    check_eq("t1_c1_mem_addr",  bus.mem_addr,  32'h100);
    check_eq("t1_c1_mem_we",    bus.mem_we,    0);
    check_eq("t1_c1_mem_wstrb", bus.mem_wstrb, 0);
    check_eq("t1_c1_stall_if",  bus.stall_if,  1);
    check_eq("t1_c1_if_valid",  bus.if_valid,  0);
    next_cycle(); sample();
    check_eq("t1_c2_if_valid", bus.if_valid, 1);
    check_eq("t1_c2_if_rdata", bus.if_rdata, 32'h00500093);
    check_eq("t1_c2_stall_if", bus.stall_if, 0);
    check_eq("t1_c2_mem_req",  bus.mem_req,  0);
    check_eq("t1_c2_dm_valid", bus.dm_valid, 0);
    next_cycle();
    bus.if_req = 1'b0; bus.mem_ready = 1'b0;
    sample();
    check_eq("t1_c3_if_valid", bus.if_valid, 0);

    // 2: simultaneous fetch and load, data served first
    next_cycle();
    bus.if_req = 1'b1; bus.if_addr = 32'h104;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h2000;
    bus.mem_ready = 1'b0;
    sample();
    check_eq("t2_c0_stall_if",  bus.stall_if,  1);
    check_eq("t2_c0_stall_mem", bus.stall_mem, 1);
    for (int c = 1; c <= 2; c++) begin
      next_cycle(); sample();
      check_eq($sformatf("t2_c%0d_mem_req", c),  bus.mem_req,  1);
      check_eq($sformatf("t2_c%0d_mem_addr", c), bus.mem_addr, 32'h2000);
      check_eq($sformatf("t2_c%0d_stall_if", c), bus.stall_if, 1);
    end
    next_cycle();
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
    sample();
    check_eq("t2_c3_mem_req",  bus.mem_req,  1);
    check_eq("t2_c3_stall_if", bus.stall_if, 1);
    next_cycle(); sample();
    check_eq("t2_c4_dm_valid",  bus.dm_valid,  1);
    check_eq("t2_c4_dm_rdata",  bus.dm_rdata,  32'hDEADBEEF);
    check_eq("t2_c4_if_valid",  bus.if_valid,  0);
    check_eq("t2_c4_stall_mem", bus.stall_mem, 0);
    check_eq("t2_c4_stall_if",  bus.stall_if,  1);
    next_cycle();
    bus.dm_req = 1'b0; bus.mem_rdata = 32'h11111111;
    sample();
    check_eq("t2_c5_dm_valid", bus.dm_valid, 0);
    check_eq("t2_c5_stall_if", bus.stall_if, 1);
    next_cycle(); sample();
    check_eq("t2_c6_mem_req",  bus.mem_req,  1);
    check_eq("t2_c6_mem_addr", bus.mem_addr, 32'h104);
    check_eq("t2_c6_mem_we",   bus.mem_we,   0);
    next_cycle(); sample();
    check_eq("t2_c7_if_valid", bus.if_valid, 1);
    check_eq("t2_c7_if_rdata", bus.if_rdata, 32'h11111111);
    check_eq("t2_c7_dm_rdata", bus.dm_rdata, 32'hDEADBEEF);
    next_cycle();
    bus.if_req = 1'b0; bus.mem_ready = 1'b0;

    // 3: store leaves dm_rdata untouched
    next_cycle();
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h2004;
    bus.dm_wdata = 32'h12345678; bus.dm_wstrb = 4'h3;
    bus.mem_rdata = 32'hCAFEF00D;
    sample();
    check_eq("t3_c0_stall_mem", bus.stall_mem, 1);
    for (int c = 1; c <= 2; c++) begin
      next_cycle(); sample();
      check_eq($sformatf("t3_c%0d_mem_req", c),   bus.mem_req,   1);
      check_eq($sformatf("t3_c%0d_mem_we", c),    bus.mem_we,    1);
      check_eq($sformatf("t3_c%0d_mem_addr", c),  bus.mem_addr,  32'h2004);
      check_eq($sformatf("t3_c%0d_mem_wdata", c), bus.mem_wdata, 32'h12345678);
      check_eq($sformatf("t3_c%0d_mem_wstrb", c), bus.mem_wstrb, 4'h3);
    end
    next_cycle();
    bus.mem_ready = 1'b1;
    next_cycle(); sample();
    check_eq("t3_c4_dm_valid", bus.dm_valid, 1);
    check_eq("t3_c4_dm_rdata", bus.dm_rdata, 32'hDEADBEEF);
    check_eq("t3_c4_err",      bus.err,      0);
    next_cycle();
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.mem_ready = 1'b0;
    sample();
    check_eq("t3_c5_dm_valid", bus.dm_valid, 0);

    // 4: fetch timeout after MAX_WAIT request cycles
    next_cycle();
    bus.if_req = 1'b1; bus.if_addr = 32'h200; bus.mem_rdata = 32'hFFFFFFFF;
    for (int c = 1; c <= MAX_WAIT; c++) begin
      next_cycle(); sample();
      check_eq($sformatf("t4_c%0d_mem_req", c), bus.mem_req, 1);
      check_eq($sformatf("t4_c%0d_err", c),     bus.err,     0);
    end
    next_cycle(); sample();
    check_eq("t4_c5_mem_req",  bus.mem_req,  0);
    check_eq("t4_c5_err",      bus.err,      1);
    check_eq("t4_c5_if_valid", bus.if_valid, 1);
    check_eq("t4_c5_if_rdata", bus.if_rdata, 0);
    next_cycle();
    bus.if_req = 1'b0;
    sample();
    check_eq("t4_c6_err",      bus.err,      1);
    check_eq("t4_c6_if_valid", bus.if_valid, 0);
    next_cycle(); sample();
    check_eq("t4_c7_err", bus.err, 1);

    // 5: reset during DM_WAIT
    next_cycle();
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h3000;
    bus.mem_rdata = 32'hA5A5A5A5;
    next_cycle(); sample();
    check_eq("t5_c1_mem_req", bus.mem_req, 1);
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    sample();
    check_eq("t5_c3_mem_req",  bus.mem_req,  0);
    check_eq("t5_c3_err",      bus.err,      0);
    check_eq("t5_c3_dm_valid", bus.dm_valid, 0);
    next_cycle();
    bus.mem_ready = 1'b1;
    sample();
    check_eq("t5_c4_mem_req",  bus.mem_req,  1);
    check_eq("t5_c4_mem_addr", bus.mem_addr, 32'h3000);
    check_eq("t5_c4_dm_valid", bus.dm_valid, 0);
    next_cycle(); sample();
    check_eq("t5_c5_dm_valid", bus.dm_valid, 1);
    check_eq("t5_c5_dm_rdata", bus.dm_rdata, 32'hA5A5A5A5);
    next_cycle();
    bus.dm_req = 1'b0; bus.mem_ready = 1'b0;

    // 6: back-to-back fetches, one completion every 3 cycles
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      bus.if_req = 1'b1; bus.if_addr = 32'h400 + 32'(4 * k); bus.mem_ready = 1'b1;
      sample();
      check_eq($sformatf("t6_f%0d_c0_if_valid", k), bus.if_valid, 0);
      next_cycle();
      bus.mem_rdata = 32'h1000 + 32'(k);
      sample();
      check_eq($sformatf("t6_f%0d_c1_mem_req", k),  bus.mem_req,  1);
      check_eq($sformatf("t6_f%0d_c1_mem_addr", k), bus.mem_addr, 32'h400 + 32'(4 * k));
      check_eq($sformatf("t6_f%0d_c1_if_valid", k), bus.if_valid, 0);
      next_cycle(); sample();
      check_eq($sformatf("t6_f%0d_c2_if_valid", k), bus.if_valid, 1);
      check_eq($sformatf("t6_f%0d_c2_if_rdata", k), bus.if_rdata, 32'h1000 + 32'(k));
    end
    next_cycle();
    bus.if_req = 1'b0; bus.mem_ready = 1'b0;
    sample();
    check_eq("t6_end_if_valid", bus.if_valid, 0);
    next_cycle(); sample();
    check_eq("t6_end_mem_req", bus.mem_req, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between instruction fetch (IF) and the load/store unit (MEM stage).
- Sequences each access as one outstanding transaction with a ready handshake toward memory.
- Returns read data to the owning requester and drives stall requests into the pipeline hazard logic.
- Sits between the IF/MEM stages and the memory/bus interface.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_WAIT, 16, cycles an issued access may wait for mem_ready before abort (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
if_req  in  1  fetch request; held stable until if_valid
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched instruction
if_valid  out  1  one-cycle completion pulse for fetch
dm_req  in  1  data request; held stable until dm_valid
dm_we  in  1  1=store, 0=load
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_wstrb  in  DATA_W/8  byte strobes
dm_rdata  out  DATA_W  load data
dm_valid  out  1  one-cycle completion pulse for data
mem_req  out  1  memory request, registered
mem_we  out  1  registered copy of winner write flag (0 for fetch)
mem_addr  out  ADDR_W  registered winner address
mem_wdata  out  DATA_W  registered store data
mem_wstrb  out  DATA_W/8  registered strobes (0 for fetch)
mem_ready  in  1  memory accepts/completes the access this cycle
mem_rdata  in  DATA_W  read data, valid when mem_req & mem_ready
stall_if  out  1  if_req & ~if_valid (combinational)
stall_mem  out  1  dm_req & ~dm_valid (combinational)
err  out  1  sticky timeout flag

Behaviour:
- Reset values: state IDLE. All registered outputs are 0: mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, if_rdata, dm_rdata, if_valid, dm_valid, err. Wait counter is 0.
- Four states: IDLE, IF_WAIT, DM_WAIT, RESP. An owner register records IF or DM.
- IDLE:
  - If dm_req is high, latch the dm_* fields into mem_*, set mem_req, owner=DM, and go to DM_WAIT.
  - Else if if_req is high, latch if_addr, set mem_we=0 and mem_wstrb=0, set mem_req, owner=IF, and go to IF_WAIT.
  - Data always wins a simultaneous request, because the MEM-stage instruction is older.
- *_WAIT:
  - mem_req stays 1 and mem_* stay stable.
  - On mem_ready: clear mem_req and go to RESP.
    - Loads capture mem_rdata into dm_rdata. Fetches capture it into if_rdata.
    - Stores leave dm_rdata unchanged.
  - Otherwise increment the wait counter.
  - Timeout: when the counter reaches MAX_WAIT-1 without mem_ready, clear mem_req, set err=1, load 0 into the owner's rdata, and go to RESP.
- RESP: pulse the owner's valid for exactly one cycle, reset the wait counter, and go to IDLE. Requests are not sampled in RESP; the held request is the one being completed.
- Latency: request seen in IDLE at cycle N, mem_req from N+1, mem_ready at cycle N+k (k>=1), valid at N+k+1. Minimum latency is 2 cycles.
- Throughput: a requester that presents a new request in the cycle after valid is arbitrated in that IDLE cycle. Back-to-back access therefore costs 3 cycles with zero-wait memory.
- Stalls are combinational. A waiting fetch stalls while a data access is served, because stall_if stays high.
- err is sticky until reset. A timed-out access still completes with valid, and the pipeline continues.
- Reset mid-transaction: the next edge with rst_n=0 forces IDLE and mem_req=0, clears any pending valid pulse, and clears err. No partial response is delivered.
- Requesters dropping req before valid is illegal. The arbiter still completes the access and pulses valid.

Test Plan:
1. Fetch only, mem_ready high on the first mem_req cycle, mem_rdata=0x00500093: if_req=1,if_addr=0x100 at cycle 0 → mem_req=1,mem_addr=0x100,mem_we=0 at cycle 1; if_valid=1,if_rdata=0x00500093 at cycle 2; stall_if=1 at cycles 0–1, 0 at cycle 2.
2. Simultaneous if_req (0x104) and load dm_req (0x2000), ready after 2 wait cycles, rdata=0xDEADBEEF → data served first with dm_valid and dm_rdata=0xDEADBEEF; fetch issues on the following IDLE cycle; stall_if is high throughout the data access.
3. Store dm_we=1, addr 0x2004, wdata=0x12345678, wstrb=0x3 → mem_we=1, mem_wstrb=0x3, mem_wdata=0x12345678 stable while waiting; dm_valid pulses; dm_rdata keeps its previous value.
4. mem_ready held 0 with MAX_WAIT=4 on a fetch → mem_req drops after 4 request cycles; err=1 and stays 1; if_valid pulses with if_rdata=0.
5. rst_n=0 in DM_WAIT → next cycle state IDLE, mem_req=0, err=0, no dm_valid pulse; after release, a held dm_req is re-issued.
6. Continuous if_req with zero-wait memory over 4 fetches → if_valid every 3 cycles; mem_addr follows each new if_addr.
